// File: rtl/lsu_dccm_bank_arb_pkg.sv
// Shared types for the DCCM bank arbiter: read-pipe entry and bank-index helper.
package lsu_dccm_bank_arb_pkg;

    localparam int BANK_IDX_W = 4;   // up to 16 banks
    localparam int OFS_W      = 3;   // up to 64-bit bank words

    typedef logic [BANK_IDX_W-1:0] bank_idx_t;

    typedef struct packed {
        logic              valid;
        bank_idx_t         lo_bank;
        bank_idx_t         hi_bank;
        logic [OFS_W-1:0]  offset;
    } dccm_rd_pipe_t;

    function automatic bank_idx_t bank_of(input logic [31:0] addr, input int bw, input int nbw);
        logic [31:0] mask;
        mask = (32'd1 << nbw) - 32'd1;
        return bank_idx_t'((addr >> bw) & mask);
    endfunction

endpackage

// File: rtl/lsu_dccm_bank_arb_rd_pipe.sv
// RD_LAT-deep freezable shift register tracking in-flight DCCM reads.
module lsu_dccm_rd_pipe
    import lsu_dccm_bank_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          freeze,
    input  dccm_rd_pipe_t in_ent,
    output dccm_rd_pipe_t out_ent
);

    dccm_rd_pipe_t stage [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
        end else if (!freeze) begin
            stage[0] <= in_ent;
            for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_ent = stage[RD_LAT-1];

endmodule

// File: rtl/lsu_dccm_bank_arb.sv
// N-bank DCCM port controller: load/store bank arbitration, read pipe, forward merge.
// Optional RV_DCCM_ECC_EN: pass ECC through on writes and in ld_raw; otherwise those fields are 0.
module lsu_dccm_bank_arb
    import lsu_dccm_bank_arb_pkg::*;
#(
    parameter int DCCM_BITS  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int NUM_BANKS  = 4,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 7
) (
    input  logic                                        clk,
    input  logic                                        rst_l,
    input  logic                                        freeze,
    input  logic                                        ld_valid,
    input  logic [DCCM_BITS-1:0]                        ld_addr,
    input  logic [DCCM_BITS-1:0]                        ld_end_addr,
    output logic                                        ld_ready,
    input  logic                                        st_valid,
    input  logic [DCCM_BITS-1:0]                        st_addr,
    input  logic [DATA_WIDTH-1:0]                       st_data,
    input  logic [ECC_WIDTH-1:0]                        st_ecc,
    output logic                                        st_commit,
    input  logic [2*DATA_WIDTH-1:0]                     fwd_data,
    input  logic [2*(DATA_WIDTH/8)-1:0]                 fwd_byteen,
    output logic [NUM_BANKS-1:0]                        bank_rden,
    output logic [NUM_BANKS-1:0]                        bank_wren,
    output logic [NUM_BANKS*DCCM_BITS-1:0]              bank_addr,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0]             bank_wr_data,
    input  logic [NUM_BANKS*(DATA_WIDTH+ECC_WIDTH)-1:0] bank_rd_data,
    output logic                                        ld_rvalid,
    output logic [DATA_WIDTH-1:0]                       ld_rdata,
    output logic [2*(DATA_WIDTH+ECC_WIDTH)-1:0]         ld_raw
);

    localparam int BYTE_W = DATA_WIDTH / 8;
    localparam int BW     = $clog2(BYTE_W);
    localparam int NBW    = $clog2(NUM_BANKS);
    localparam int EW     = DATA_WIDTH + ECC_WIDTH;
    localparam int SW     = $clog2(STARVE_MAX + 1);

    bank_idx_t      lo_bank, hi_bank, st_bank;
    logic           conflict, starve_max;
    logic [SW-1:0]  starve_cnt;

    assign lo_bank = bank_of(32'(ld_addr), BW, NBW);
    assign hi_bank = bank_of(32'(ld_end_addr), BW, NBW);
    assign st_bank = bank_of(32'(st_addr), BW, NBW);

    assign conflict   = ld_valid & ((st_bank == lo_bank) | (st_bank == hi_bank));
    assign starve_max = (starve_cnt == SW'(STARVE_MAX));
    assign st_commit  = st_valid & ~freeze & (~conflict | starve_max);
    assign ld_ready   = ld_valid & ~freeze & ~(st_valid & starve_max & conflict);

    // A starved store takes the bank from the load, so rden/wren never collide.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_rden[b] = ld_ready & ((lo_bank == bank_idx_t'(b)) | (hi_bank == bank_idx_t'(b)));
        assign bank_wren[b] = st_commit & (st_bank == bank_idx_t'(b));
        assign bank_addr[b*DCCM_BITS +: DCCM_BITS] =
            !bank_rden[b]                 ? st_addr :
            (lo_bank == bank_idx_t'(b))   ? ld_addr : ld_end_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_l)                                  starve_cnt <= '0;
        else if (st_commit)                          starve_cnt <= '0;
        else if (st_valid && !freeze && !starve_max) starve_cnt <= starve_cnt + 1'b1;
    end

    dccm_rd_pipe_t pipe_in, pipe_out;

    always_comb begin
        pipe_in         = '0;
        pipe_in.valid   = ld_ready;
        pipe_in.lo_bank = lo_bank;
        pipe_in.hi_bank = hi_bank;
        pipe_in.offset  = OFS_W'(ld_addr[BW-1:0]);
    end

    lsu_dccm_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk     (clk),
        .rst_l   (rst_l),
        .freeze  (freeze),
        .in_ent  (pipe_in),
        .out_ent (pipe_out)
    );

    logic [EW-1:0]           lo_w, hi_w;
    logic [2*DATA_WIDTH-1:0] rd_merged;
    logic [DATA_WIDTH-1:0]   rd_shifted;
    logic [2*EW-1:0]         raw_n;
    int                      ofs;

    always_comb begin
        lo_w = '0;
        hi_w = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (pipe_out.lo_bank == bank_idx_t'(b)) lo_w = bank_rd_data[b*EW +: EW];
            if (pipe_out.hi_bank == bank_idx_t'(b)) hi_w = bank_rd_data[b*EW +: EW];
        end
    end

    // Forwarded store bytes override bank bytes before alignment.
    always_comb begin
        rd_merged = {hi_w[DATA_WIDTH-1:0], lo_w[DATA_WIDTH-1:0]};
        for (int i = 0; i < 2*BYTE_W; i++)
            if (fwd_byteen[i]) rd_merged[8*i +: 8] = fwd_data[8*i +: 8];
        ofs = int'(pipe_out.offset) & (BYTE_W - 1);
        rd_shifted = '0;
        for (int i = 0; i < BYTE_W; i++)
            rd_shifted[8*i +: 8] = rd_merged[8*(i+ofs) +: 8];
    end

`ifdef RV_DCCM_ECC_EN
    assign bank_wr_data = {st_ecc, st_data};
    assign raw_n        = {hi_w, lo_w};
`else
    logic unused_ecc;
    assign unused_ecc   = ^{st_ecc, hi_w[EW-1:DATA_WIDTH], lo_w[EW-1:DATA_WIDTH]};
    assign bank_wr_data = {{ECC_WIDTH{1'b0}}, st_data};
    assign raw_n        = {{ECC_WIDTH{1'b0}}, hi_w[DATA_WIDTH-1:0],
                           {ECC_WIDTH{1'b0}}, lo_w[DATA_WIDTH-1:0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
            ld_raw    <= '0;
        end else if (!freeze) begin
            ld_rvalid <= pipe_out.valid;
            if (pipe_out.valid) begin
                ld_rdata <= rd_shifted;
                ld_raw   <= raw_n;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dccm_bank_arb.sv
// Scoreboard bench for lsu_dccm_bank_arb with a latency-accurate banked memory model.
module tb_lsu_dccm_bank_arb;

    localparam int DB = 16, DW = 32, EW = 7, NB = 4, RL = 3, SM = 7;
    localparam int WW = DW + EW;

    logic clk, rst_l, freeze;
    logic ld_valid, ld_ready, st_valid, st_commit, ld_rvalid;
    logic [DB-1:0] ld_addr, ld_end_addr, st_addr;
    logic [DW-1:0] st_data, ld_rdata;
    logic [EW-1:0] st_ecc;
    logic [2*DW-1:0] fwd_data;
    logic [7:0] fwd_byteen;
    logic [NB-1:0] bank_rden, bank_wren;
    logic [NB*DB-1:0] bank_addr;
    logic [WW-1:0] bank_wr_data;
    logic [NB*WW-1:0] bank_rd_data;
    logic [2*WW-1:0] ld_raw;

    lsu_dccm_bank_arb #(.DCCM_BITS(DB), .DATA_WIDTH(DW), .ECC_WIDTH(EW), .NUM_BANKS(NB),
                        .RD_LAT(RL), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_l(rst_l), .freeze(freeze),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_end_addr(ld_end_addr), .ld_ready(ld_ready),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ecc(st_ecc),
        .st_commit(st_commit), .fwd_data(fwd_data), .fwd_byteen(fwd_byteen),
        .bank_rden(bank_rden), .bank_wren(bank_wren), .bank_addr(bank_addr),
        .bank_wr_data(bank_wr_data), .bank_rd_data(bank_rd_data),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_raw(ld_raw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] init_mem(input int b, input int w);
        logic [31:0] v;
        v = 32'h9E3779B9 * 32'(b*64 + w + 1);
        if (b == 1 && w == 0) v = 32'hDEADBEEF;
        return {EW'(b*9 + w + 1), v};
    endfunction

    // Bank memory: read data appears RD_LAT unfrozen cycles after the address.
    logic [WW-1:0] mem [NB][64];
    logic [5:0]    dl  [NB][RL];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!rst_l) for (int w = 0; w < 64; w++) mem[b][w] <= init_mem(b, w);
            else if (bank_wren[b]) mem[b][bank_addr[b*DB+4 +: 6]] <= bank_wr_data;
            if (!freeze) begin
                dl[b][0] <= bank_addr[b*DB+4 +: 6];
                for (int k = 1; k < RL; k++) dl[b][k] <= dl[b][k-1];
            end
        end
    end

    always_comb begin
        bank_rd_data = '0;
        for (int b = 0; b < NB; b++) bank_rd_data[b*WW +: WW] = mem[b][dl[b][RL-1]];
    end

    typedef struct {
        logic [DW-1:0]   data;
        logic [2*WW-1:0] raw;
        int              due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [NB][64];
    int          ucnt = 0;
    logic        frz_q = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] lw, hw;
        logic [63:0] m;
        if (!rst_l) begin
            sb.delete();
            for (int b = 0; b < NB; b++)
                for (int w = 0; w < 64; w++) ref_mem[b][w] = init_mem(b, w)[DW-1:0];
        end else begin
            if (ld_rvalid && !frz_q) begin
                if (sb.size() == 0) chk("spurious_rvalid", ld_rvalid, 0);
                else begin
                    e = sb.pop_front();
                    chk("ld_rdata", ld_rdata, e.data);
                    chk("ld_raw", ld_raw, e.raw);
                    chk("latency", ucnt, e.due);
                end
            end
            if (ld_ready) begin
                lw = ref_mem[ld_addr[3:2]][ld_addr[9:4]];
                hw = ref_mem[ld_end_addr[3:2]][ld_end_addr[9:4]];
                m  = {hw, lw};
                for (int i = 0; i < 8; i++) if (fwd_byteen[i]) m[8*i +: 8] = fwd_data[8*i +: 8];
                m = m >> (8 * ld_addr[1:0]);
                e.data = m[31:0];
                e.raw  = {7'b0, hw, 7'b0, lw};
                e.due  = ucnt + RL + 1;
                sb.push_back(e);
            end
            if (st_commit) ref_mem[st_addr[3:2]][st_addr[9:4]] = st_data;
        end
        frz_q = freeze;
        if (!freeze) ucnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DB-1:0] a, input logic [DB-1:0] ea);
        ld_valid = 1'b1; ld_addr = a; ld_end_addr = ea;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("drain", sb.size(), 0);
    endtask

    task automatic starve_run(input logic [DB-1:0] sa, input logic [DW-1:0] sd);
        st_valid = 1'b1; st_addr = sa; st_data = sd;
        ld_valid = 1'b1; ld_addr = 16'h0004; ld_end_addr = 16'h0007;
        for (int c = 0; c <= SM; c++) begin
            @(negedge clk);
            chk("starve_commit", st_commit, c == SM);
            chk("starve_ready", ld_ready, c != SM);
            tick();
        end
        st_valid = 1'b0; ld_valid = 1'b0;
    endtask

    initial begin
        rst_l = 1'b0; freeze = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_end_addr = '0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_ecc = 7'h55;
        fwd_data = '0; fwd_byteen = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_rvalid", ld_rvalid, 0);
        chk("rst_rdata", ld_rdata, 0);
        chk("rst_raw", ld_raw, 0);
        chk("idle_rden", bank_rden, 0);
        chk("idle_wren", bank_wren, 0);
        tick();
        rst_l = 1'b1;
        tick();

        // aligned word from bank 1
        ld_valid = 1'b1; ld_addr = 16'h0004; ld_end_addr = 16'h0007;
        @(negedge clk);
        chk("t1_rden", bank_rden, 4'b0010);
        chk("t1_ready", ld_ready, 1);
        tick(); ld_valid = 1'b0;
        drain();

        // unaligned load over banks 1/2 with a store to bank 3 in the same cycle
        ld_valid = 1'b1; ld_addr = 16'h0006; ld_end_addr = 16'h0009;
        st_valid = 1'b1; st_addr = 16'h000C; st_data = 32'hCAFEF00D;
        @(negedge clk);
        chk("t2_rden", bank_rden, 4'b0110);
        chk("t2_wren", bank_wren, 4'b1000);
        chk("t2_commit", st_commit, 1);
        chk("t2_ready", ld_ready, 1);
        chk("t2_addr1", bank_addr[1*DB +: DB], 16'h0006);
        chk("t2_addr2", bank_addr[2*DB +: DB], 16'h0009);
        chk("t2_addr3", bank_addr[3*DB +: DB], 16'h000C);
        chk("t2_wdata", bank_wr_data, {7'b0, 32'hCAFEF00D});
        tick(); ld_valid = 1'b0; st_valid = 1'b0;
        load(16'h000C, 16'h000F);
        load(16'h0007, 16'h0007);
        drain();

        // store starvation against back-to-back bank-1 loads
        starve_run(16'h0014, 32'h0BADC0DE);
        tick();
        load(16'h0014, 16'h0017);
        drain();

        // store-buffer forwarding, aligned then unaligned into the hi lane
        fwd_data = {32'hAABBCCDD, 32'h11223344}; fwd_byteen = 8'h0F;
        load(16'h0020, 16'h0023);
        drain();
        fwd_byteen = 8'h30;
        load(16'h0022, 16'h0025);
        drain();
        fwd_byteen = '0;

        // freeze for 3 cycles while a load sits mid-pipe
        load(16'h0030, 16'h0033);
        tick();
        freeze = 1'b1;
        ld_valid = 1'b1; ld_addr = 16'h0040; ld_end_addr = 16'h0043;
        st_valid = 1'b1; st_addr = 16'h0018; st_data = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_ready", ld_ready, 0);
            chk("frz_commit", st_commit, 0);
            chk("frz_rden", bank_rden, 0);
            chk("frz_rvalid", ld_rvalid, 0);
            tick();
        end
        freeze = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
        drain();

        // reset with loads in flight and a partly starved store
        st_valid = 1'b1; st_addr = 16'h0014; st_data = 32'h5A5A5A5A;
        load(16'h0004, 16'h0007);
        load(16'h0008, 16'h000B);
        st_valid = 1'b0;
        rst_l = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("r6_rvalid", ld_rvalid, 0);
        chk("r6_rdata", ld_rdata, 0);
        chk("r6_raw", ld_raw, 0);
        tick();
        rst_l = 1'b1;
        for (int i = 0; i < RL + 3; i++) begin
            @(negedge clk);
            chk("r6_no_rvalid", ld_rvalid, 0);
            tick();
        end
        starve_run(16'h0024, 32'h600DF00D);
        tick();
        load(16'h0024, 16'h0027);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
